// File: rtl/flipflop_i_register.sv
// FLIPFLOP_I instruction-state register: holds the current I-state code, its
// previous value, a stuck-state watchdog and sticky conflict/watchdog error flags.
module flipflop_i_register #(
  parameter logic [7:0] WD_LIMIT = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] encoded_i,
  input  logic       set_any,
  input  logic       clear,
  input  logic       advance,
  input  logic       stall,
  input  logic       err_ack,
  output logic [7:0] i_state,
  output logic [7:0] i_prev,
  output logic       i_active,
  output logic       conflict,
  output logic       wd_err
);

  localparam int unsigned W = 8;

  logic [W-1:0] state_q, state_d;
  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         conflict_q, conflict_d;
  logic         wd_err_q, wd_err_d;
  logic         trip;
  logic         changed;

  // Next-state: stall > watchdog trip > clear > set_any > advance > hold.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    conflict_d = conflict_q;
    wd_err_d   = wd_err_q;
    trip       = 1'b0;
    changed    = 1'b0;

    if (!stall) begin
      trip = (state_q != '0) && (cnt_q == WD_LIMIT);

      if (trip) begin
        state_d = '0;
      end else if (clear) begin
        state_d = '0;
      end else if (set_any) begin
        state_d = encoded_i;
      end else if (advance) begin
        if (state_q[0]) begin
          state_d = '0;
        end else if (state_q != '0) begin
          state_d = state_q | W'(1);
        end
      end

      // An identical reload is not a change: i_prev and the watchdog keep going.
      changed = (state_d != state_q);
      if (changed) begin
        prev_d = state_q;
      end

      if (trip || changed || (state_q == '0)) begin
        cnt_d = '0;
      end else if (cnt_q < WD_LIMIT) begin
        cnt_d = cnt_q + W'(1);
      end

      // Flag-setting events override an acknowledge in the same cycle.
      if (err_ack) begin
        conflict_d = 1'b0;
        wd_err_d   = 1'b0;
      end
      if (set_any && clear) begin
        conflict_d = 1'b1;
      end
      if (trip) begin
        wd_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
      wd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
      wd_err_q   <= wd_err_d;
    end
  end

  assign i_state  = state_q;
  assign i_prev   = prev_q;
  assign i_active = (state_q != '0);
  assign conflict = conflict_q;
  assign wd_err   = wd_err_q;

endmodule

// File: tb/tb_flipflop_i_register.sv
// Directed testbench for flipflop_i_register, built with a 4-cycle watchdog limit.
module tb_flipflop_i_register;

  logic       clk;
  logic       rst_n;
  logic [7:0] encoded_i;
  logic       set_any;
  logic       clear;
  logic       advance;
  logic       stall;
  logic       err_ack;
  logic [7:0] i_state;
  logic [7:0] i_prev;
  logic       i_active;
  logic       conflict;
  logic       wd_err;

  int checks = 0;
  int errors = 0;

  flipflop_i_register #(.WD_LIMIT(8'd4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .encoded_i (encoded_i),
    .set_any   (set_any),
    .clear     (clear),
    .advance   (advance),
    .stall     (stall),
    .err_ack   (err_ack),
    .i_state   (i_state),
    .i_prev    (i_prev),
    .i_active  (i_active),
    .conflict  (conflict),
    .wd_err    (wd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    encoded_i = 8'h00;
    set_any   = 1'b0;
    clear     = 1'b0;
    advance   = 1'b0;
    stall     = 1'b0;
    err_ack   = 1'b0;
  endtask

  // One rising edge, then settle 1 time unit before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    checks++; if (i_state !== 8'h00) begin errors++; $display("FAIL reset_i_state got %h exp 00", i_state); end
    checks++; if (i_prev !== 8'h00) begin errors++; $display("FAIL reset_i_prev got %h exp 00", i_prev); end
    checks++; if (i_active !== 1'b0) begin errors++; $display("FAIL reset_i_active got %b exp 0", i_active); end
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b exp 0", conflict); end
    checks++; if (wd_err !== 1'b0) begin errors++; $display("FAIL reset_wd_err got %b exp 0", wd_err); end
    @(negedge clk);
    rst_n     = 1'b1;
    set_any   = 1'b1;
    encoded_i = 8'h5A;
    tick();
    checks++; if (i_state !== 8'h5A) begin errors++; $display("FAIL first_edge_load got %h exp 5a", i_state); end
    idle_inputs();
    clear = 1'b1;
    tick();
    checks++; if (i_state !== 8'h00) begin errors++; $display("FAIL clear got %h exp 00", i_state); end
    checks++; if (i_prev !== 8'h5A) begin errors++; $display("FAIL clear_prev got %h exp 5a", i_prev); end
    idle_inputs();
  endtask

  task automatic test_sequence();
    set_any = 1'b1; encoded_i = 8'h1C;
    tick();
    checks++; if (i_state !== 8'h1C || i_prev !== 8'h00 || i_active !== 1'b1) begin
      errors++; $display("FAIL seq_load got %h/%h/%b exp 1c/00/1", i_state, i_prev, i_active); end
    idle_inputs(); advance = 1'b1;
    tick();
    checks++; if (i_state !== 8'h1D || i_prev !== 8'h1C) begin
      errors++; $display("FAIL seq_adv1 got %h/%h exp 1d/1c", i_state, i_prev); end
    tick();
    checks++; if (i_state !== 8'h00 || i_prev !== 8'h1D || i_active !== 1'b0) begin
      errors++; $display("FAIL seq_adv2 got %h/%h/%b exp 00/1d/0", i_state, i_prev, i_active); end
    idle_inputs();
  endtask

  task automatic test_stall();
    set_any = 1'b1; encoded_i = 8'h74;
    tick();
    checks++; if (i_state !== 8'h74) begin errors++; $display("FAIL stall_pre got %h exp 74", i_state); end
    stall = 1'b1; encoded_i = 8'h35; clear = 1'b1; advance = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_any = (i % 2 == 0);
      tick();
      checks++; if (i_state !== 8'h74 || i_prev !== 8'h00 || conflict !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d] got %h/%h/%b exp 74/00/0", i, i_state, i_prev, conflict); end
    end
    idle_inputs(); set_any = 1'b1; encoded_i = 8'h35;
    tick();
    checks++; if (i_state !== 8'h35 || i_prev !== 8'h74) begin
      errors++; $display("FAIL stall_after got %h/%h exp 35/74", i_state, i_prev); end
    idle_inputs(); clear = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_conflict();
    set_any = 1'b1; encoded_i = 8'hCC; clear = 1'b1;
    tick();
    checks++; if (i_state !== 8'h00 || conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_set got %h/%b exp 00/1", i_state, conflict); end
    idle_inputs();
    tick();
    checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL conflict_sticky got %b exp 1", conflict); end
    err_ack = 1'b1;
    tick();
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL conflict_ack got %b exp 0", conflict); end
    set_any = 1'b1; clear = 1'b1; encoded_i = 8'h12;
    tick();
    checks++; if (conflict !== 1'b1 || i_state !== 8'h00) begin
      errors++; $display("FAIL conflict_beats_ack got %b/%h exp 1/00", conflict, i_state); end
    idle_inputs(); err_ack = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_watchdog();
    set_any = 1'b1; encoded_i = 8'h4E;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();
    checks++; if (i_state !== 8'h4E || wd_err !== 1'b0) begin
      errors++; $display("FAIL wd_pretrip got %h/%b exp 4e/0", i_state, wd_err); end
    tick();
    checks++; if (i_state !== 8'h00 || wd_err !== 1'b1 || i_prev !== 8'h4E) begin
      errors++; $display("FAIL wd_trip got %h/%b/%h exp 00/1/4e", i_state, wd_err, i_prev); end
    tick();
    checks++; if (wd_err !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b exp 1", wd_err); end
    err_ack = 1'b1;
    tick();
    checks++; if (wd_err !== 1'b0) begin errors++; $display("FAIL wd_ack got %b exp 0", wd_err); end
    idle_inputs();
  endtask

  task automatic test_idle_noop();
    advance = 1'b1;
    tick();
    checks++; if (i_state !== 8'h00 || i_prev !== 8'h4E || conflict !== 1'b0 || wd_err !== 1'b0) begin
      errors++; $display("FAIL idle_advance got %h/%h/%b/%b exp 00/4e/0/0", i_state, i_prev, conflict, wd_err); end
    idle_inputs(); set_any = 1'b1; encoded_i = 8'h00;
    tick();
    checks++; if (i_state !== 8'h00 || i_prev !== 8'h4E || conflict !== 1'b0 || wd_err !== 1'b0) begin
      errors++; $display("FAIL idle_load_zero got %h/%h/%b/%b exp 00/4e/0/0", i_state, i_prev, conflict, wd_err); end
    encoded_i = 8'h22;
    tick();
    tick();
    checks++; if (i_state !== 8'h22 || i_prev !== 8'h00) begin
      errors++; $display("FAIL same_reload got %h/%h exp 22/00", i_state, i_prev); end
    idle_inputs(); clear = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    set_any = 1'b1; encoded_i = 8'hF4;
    tick();
    idle_inputs();
    checks++; if (i_state !== 8'hF4) begin errors++; $display("FAIL areset_pre got %h exp f4", i_state); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (i_state !== 8'h00 || i_prev !== 8'h00 || i_active !== 1'b0 || conflict !== 1'b0 || wd_err !== 1'b0) begin
      errors++; $display("FAIL areset_now got %h/%h/%b/%b/%b exp 00/00/0/0/0", i_state, i_prev, i_active, conflict, wd_err); end
    @(negedge clk);
    rst_n = 1'b1;
    set_any = 1'b1; encoded_i = 8'h11;
    tick();
    checks++; if (i_state !== 8'h11 || i_prev !== 8'h00) begin
      errors++; $display("FAIL areset_recover got %h/%h exp 11/00", i_state, i_prev); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_conflict();
    test_watchdog();
    test_idle_noop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flipflop_i_register.md
FLIPFLOP_I_REGISTER -- requirements
Module: flipflop_i_register

Interface
REQ-001 SHALL have parameter WD_LIMIT, default 8'd255: count of unchanged, unstalled non-idle cycles that trips the watchdog.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port encoded_i, input, 8: next I-state code, one bit per FLIPFLOP_I encoder (bit n = encodedn).
REQ-005 SHALL have port set_any, input, 1: OR of all P2_Set_* strobes; encoded_i is valid this cycle.
REQ-006 SHALL have port clear, input, 1: instruction complete; return to idle.
REQ-007 SHALL have port advance, input, 1: step the byte-pair sequence (_0 to _1 to idle).
REQ-008 SHALL have port stall, input, 1: memory wait; freeze all state.
REQ-009 SHALL have port err_ack, input, 1: clears the sticky error flags.
REQ-010 SHALL have port i_state, output, 8: current I-state code; 8'h00 means idle.
REQ-011 SHALL have port i_prev, output, 8: i_state value before its most recent change.
REQ-012 SHALL have port i_active, output, 1: combinational (i_state != 8'h00).
REQ-013 SHALL have port conflict, output, 1: sticky; set_any and clear were seen in the same cycle.
REQ-014 SHALL have port wd_err, output, 1: sticky; the watchdog tripped.

Function
REQ-015 SHALL apply this per-cycle update priority: stall, then watchdog trip, then clear, then set_any, then advance, then hold.
REQ-016 SHALL, while stall=1, hold i_state, i_prev, the watchdog counter and both flags; all other inputs are ignored.
REQ-017 SHALL, on clear=1 (not stalled), load i_state=8'h00.
REQ-018 SHALL, on set_any=1 with clear=0 (not stalled), load i_state=encoded_i; latency is 1 cycle from strobe to output.
REQ-019 SHALL, on advance=1 alone with i_state[0]=0 and i_state nonzero, set i_state[0]=1.
REQ-020 SHALL, on advance=1 alone with i_state[0]=1, load i_state=8'h00.
REQ-021 SHALL treat advance while idle as a no-op.
REQ-022 SHALL treat set_any with encoded_i=8'h00 as a legal load to idle.
REQ-023 SHALL, on set_any=1 and clear=1 in the same unstalled cycle, let clear win and set conflict on the next edge.
REQ-024 SHALL update i_prev with the old i_state only on cycles where i_state actually changes value; a reload of an identical value changes nothing.
REQ-025 SHALL keep an internal 8-bit watchdog counter that resets to 0 on any i_state change or while i_state=8'h00.
REQ-026 SHALL increment the watchdog counter when i_state is nonzero, unchanged and unstalled, saturating at WD_LIMIT.
REQ-027 SHALL, when the counter equals WD_LIMIT on an unstalled cycle, force i_state=8'h00 (i_prev updates), set wd_err and zero the counter.
REQ-028 SHALL clear conflict and wd_err on err_ack=1 (not stalled); a flag-setting event in the same cycle wins over err_ack.
REQ-029 SHALL keep the sticky flags otherwise unchanged until err_ack or reset.

Reset
REQ-030 SHALL, with rst_n=0, asynchronously force i_state=8'h00, i_prev=8'h00, watchdog counter=0, conflict=0 and wd_err=0, regardless of clk or stall.
REQ-031 SHALL abandon any in-progress sequence when reset asserts mid-operation; no partial state survives.
REQ-032 SHALL leave the block idle after rst_n deasserts and accept set_any on the first rising edge after deassertion.

Verification
REQ-033 SHALL be checked by: set_any with encoded_i=8'h1C, then advance twice -> i_state reads 8'h1C, 8'h1D, 8'h00 on successive edges; i_prev reads 8'h00, 8'h1C, 8'h1D.
REQ-034 SHALL be checked by: i_state=8'h74, stall=1 for 5 cycles with set_any pulsed (encoded_i=8'h35) -> i_state stays 8'h74; after stall=0, the next set_any loads 8'h35.
REQ-035 SHALL be checked by: set_any=1 with encoded_i=8'hCC and clear=1 in the same cycle -> i_state=8'h00 and conflict=1; err_ack -> conflict=0.
REQ-036 SHALL be checked by: WD_LIMIT=4, load 8'h4E, then idle inputs -> i_state=8'h00 and wd_err=1 five edges after the load; i_prev=8'h4E.
REQ-037 SHALL be checked by: rst_n pulled low asynchronously between edges while i_state=8'hF4 -> all outputs read 0 immediately, with no clock edge.
REQ-038 SHALL be checked by: advance while idle, and set_any with encoded_i=8'h00 -> i_state remains 8'h00, i_prev is unchanged, and no flags are set.
